// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub/and/or/beq/blt, iterative shift-add mul and 1-bit/cycle shifts.
// Latency 1 (simple ops, shamt 0), WIDTH+1 (mul), shamt+1 (shifts); start while busy is dropped, not queued.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] ip_0,
  input  logic [WIDTH-1:0] ip_1,
  output logic [WIDTH-1:0] op_0,
  output logic             change_pc,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [3:0] OP_BEQ = 4'd2;
  localparam logic [3:0] OP_BLT = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_SLL = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;

  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_FULL = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_0_nxt;
  logic             change_pc_nxt, err_nxt, done_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;   // mul multiplicand, or the shift working value
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [SHW:0]     cnt, cnt_nxt;       // one extra bit so it can hold WIDTH
  logic             shift_right, shift_right_nxt;
  logic [WIDTH-1:0] acc_sum, shifted;
  logic [SHW-1:0]   shamt;

  assign busy  = (state != IDLE);
  assign shamt = ip_1[SHW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_0        <= '0;
      change_pc   <= 1'b0;
      err         <= 1'b0;
      done        <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
      shift_right <= 1'b0;
    end else begin
      state       <= state_nxt;
      op_0        <= op_0_nxt;
      change_pc   <= change_pc_nxt;
      err         <= err_nxt;
      done        <= done_nxt;
      acc         <= acc_nxt;
      mcand       <= mcand_nxt;
      mplier      <= mplier_nxt;
      cnt         <= cnt_nxt;
      shift_right <= shift_right_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    op_0_nxt        = op_0;
    change_pc_nxt   = change_pc;
    err_nxt         = err;
    done_nxt        = 1'b0;
    acc_nxt         = acc;
    mcand_nxt       = mcand;
    mplier_nxt      = mplier;
    cnt_nxt         = cnt;
    shift_right_nxt = shift_right;
    acc_sum         = mplier[0] ? (acc + mcand) : acc;
    shifted         = shift_right ? (mcand >> 1) : (mcand << 1);

    case (state)
      IDLE: begin
        if (start) begin
          case (opcode)
            OP_BEQ, OP_BLT: begin
              // branch compares leave op_0 untouched
              change_pc_nxt = (opcode == OP_BEQ) ? (ip_0 == ip_1) : (ip_0 < ip_1);
              err_nxt       = 1'b0;
              done_nxt      = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              case (opcode)
                OP_ADD:  op_0_nxt = ip_0 + ip_1;
                OP_SUB:  op_0_nxt = ip_0 - ip_1;
                OP_AND:  op_0_nxt = ip_0 & ip_1;
                default: op_0_nxt = ip_0 | ip_1;
              endcase
              change_pc_nxt = 1'b0;
              err_nxt       = 1'b0;
              done_nxt      = 1'b1;
            end
            OP_MUL: begin
              mcand_nxt  = ip_0;
              mplier_nxt = ip_1;
              acc_nxt    = '0;
              cnt_nxt    = CNT_FULL;
              state_nxt  = MUL;
            end
            OP_SLL, OP_SRL: begin
              if (shamt == '0) begin
                op_0_nxt      = ip_0;
                change_pc_nxt = 1'b0;
                err_nxt       = 1'b0;
                done_nxt      = 1'b1;
              end else begin
                mcand_nxt       = ip_0;
                cnt_nxt         = {1'b0, shamt};
                shift_right_nxt = (opcode == OP_SRL);
                state_nxt       = SHIFT;
              end
            end
            default: begin
              op_0_nxt      = '0;
              change_pc_nxt = 1'b0;
              err_nxt       = 1'b1;
              done_nxt      = 1'b1;
            end
          endcase
        end
      end
      MUL: begin
        acc_nxt    = acc_sum;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          op_0_nxt      = acc_sum;
          change_pc_nxt = 1'b0;
          err_nxt       = 1'b0;
          done_nxt      = 1'b1;
          state_nxt     = IDLE;
        end
      end
      SHIFT: begin
        mcand_nxt = shifted;
        cnt_nxt   = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          op_0_nxt      = shifted;
          change_pc_nxt = 1'b0;
          err_nxt       = 1'b0;
          done_nxt      = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): scoreboard of expected results checked at each done pulse.
module tb_seq_alu;

  typedef struct {
    logic [31:0] op;
    logic        cp;
    logic        er;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic [31:0] ip_0 = 32'd0;
  logic [31:0] ip_1 = 32'd0;
  logic [31:0] op_0;
  logic        change_pc, busy, done, err;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          t_issue = 0;
  int          exp_lat = 1;
  logic [31:0] model_op = 32'd0;
  exp_t        q[$];

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .ip_0(ip_0), .ip_1(ip_1), .op_0(op_0), .change_pc(change_pc),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      vectors++;
      assert (q.size() != 0) else begin
        miscompares++;
        $error("FAIL spurious_done: observed done with no outstanding op, expected none");
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("op_0", op_0, e.op);
        check("change_pc", {31'd0, change_pc}, {31'd0, e.cp});
        check("err", {31'd0, err}, {31'd0, e.er});
      end
    end
  end

  // Reference behaviour and latency of one accepted operation.
  task automatic issue(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    start = 1'b1; opcode = opc; ip_0 = a; ip_1 = b;
    e.op = model_op; e.cp = 1'b0; e.er = 1'b0;
    exp_lat = 1;
    case (opc)
      4'd2: e.cp = (a == b);
      4'd3: e.cp = (a < b);
      4'd4: e.op = a + b;
      4'd5: e.op = a - b;
      4'd6: e.op = a & b;
      4'd7: e.op = a | b;
      4'd8: begin e.op = a * b; exp_lat = 33; end
      4'd9: begin e.op = a << b[4:0]; exp_lat = int'(b[4:0]) + 1; end
      4'd10: begin e.op = a >> b[4:0]; exp_lat = int'(b[4:0]) + 1; end
      default: begin e.op = 32'd0; e.er = 1'b1; end
    endcase
    model_op = e.op;
    q.push_back(e);
    t_issue = cyc;
  endtask

  // Wait for done (bounded); optionally pulse an add start at wait step inj while busy.
  task automatic wait_done(input int inj);
    int n;
    int busy_cnt;
    busy_cnt = 0;
    n = 1;
    @(negedge clk);
    start = 1'b0; ip_0 = $urandom; ip_1 = $urandom; opcode = 4'($urandom_range(0, 15));
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
      start = (n == inj);
      if (n == inj) begin opcode = 4'd4; ip_0 = 32'd1; ip_1 = 32'd1; end
    end
    start = 1'b0;
    check("latency", cyc - t_issue, exp_lat);
    check("busy_cycles", busy_cnt, exp_lat - 1);
  endtask

  initial begin
    exp_t dummy;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_op_0", op_0, 32'd0);
    check("rst_change_pc", {31'd0, change_pc}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    issue(4'd4, 32'hFFFF_FFFF, 32'd1);        wait_done(0);
    issue(4'd5, 32'd3, 32'd5);                wait_done(0);
    issue(4'd2, 32'd7, 32'd7);                wait_done(0);
    issue(4'd3, 32'd5, 32'd3);                wait_done(0);
    issue(4'd6, 32'hF0F0, 32'hFF00);          wait_done(0);
    issue(4'd8, 32'h1234, 32'h10);            wait_done(6);
    issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(0);
    issue(4'd9, 32'd1, 32'd31);               wait_done(0);
    issue(4'd10, 32'h8000_0000, 32'd0);       wait_done(0);
    issue(4'd10, 32'hF0, 32'd4);              wait_done(0);
    issue(4'd15, 32'h55, 32'hAA);             wait_done(0);
    issue(4'd4, 32'd10, 32'd20);              wait_done(0);

    // Single-cycle ops issued every cycle produce done every cycle.
    issue(4'd7, 32'h0F00, 32'h00F0);
    issue(4'd4, 32'd100, 32'd23);
    check("b2b_done_1", {31'd0, done}, 32'd1);
    issue(4'd2, 32'd1, 32'd2);
    check("b2b_done_2", {31'd0, done}, 32'd1);
    issue(4'd5, 32'd0, 32'd1);
    check("b2b_done_3", {31'd0, done}, 32'd1);
    wait_done(0);

    // Reset in the middle of a multiply abandons it silently.
    issue(4'd8, 32'hDEAD, 32'hBEEF);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    while (q.size() != 0) dummy = q.pop_front();
    model_op = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_op_0", op_0, 32'd0);
    check("mid_rst_change_pc", {31'd0, change_pc}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_done", {31'd0, done}, 32'd0);
    end
    issue(4'd4, 32'd6, 32'd7);                wait_done(0);

    for (int i = 0; i < 12; i++) begin
      logic [3:0]  opc;
      logic [31:0] b;
      opc = (i % 6 == 5) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(2, 10));
      b = $urandom;
      if (opc == 4'd9 || opc == 4'd10) b = 32'($urandom_range(0, 31));
      issue(opc, $urandom, b);
      wait_done(0);
    end

    @(negedge clk);
    check("scoreboard_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
